rvfpm_result_arb: RTL

Round-robin arbiter that shares the single CORE-V-XIF result interface of the FPU model between several internal result producers, e.g. arithmetic pipeline writeback and load writeback. It holds one registered output slot so that `result_*` stays stable while `result_valid` is high and `result_ready` is low. It also drops results whose instruction ID the core has killed through the commit interface, and counts those drops.

---
 rtl/pa_rvfpm.sv | 18 +
 rtl/rvfpm_rr_arb.sv | 36 +++
 rtl/rvfpm_result_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/pa_rvfpm.sv
// Shared types and helpers for the FPU-model result path.
package pa_rvfpm;

  localparam int DROP_CNT_W    = 16;
  localparam int PA_X_ID_WIDTH = 4;
  localparam int PA_FLEN       = 32;

  typedef struct packed {
    logic [PA_X_ID_WIDTH-1:0] id;
    logic [4:0]               rd;
    logic [PA_FLEN-1:0]       data;
  } res_src_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rvfpm_rr_arb.sv
// Combinational round-robin pick: first request at or after i_ptr, circularly.
module rvfpm_rr_arb #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic          w_found;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_cand;

  // NOTE: every output and temporary gets a default first so no latch is inferred.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_cand = w_sum[PW-1:0];
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/rvfpm_result_arb.sv
// Shares the XIF result port among NUM_SRC producers, holding one output slot
// and discarding results whose ID the core has killed.
module rvfpm_result_arb
  import pa_rvfpm::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int X_ID_WIDTH = 4,
  parameter int FLEN       = 32
) (
  input  logic                          ck,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*X_ID_WIDTH-1:0] src_id,
  input  logic [NUM_SRC*5-1:0]          src_rd,
  input  logic [NUM_SRC*FLEN-1:0]       src_data,
  input  logic                          commit_valid,
  input  logic [X_ID_WIDTH-1:0]         commit_id,
  input  logic                          commit_kill,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [X_ID_WIDTH-1:0]         result_id,
  output logic [4:0]                    result_rd,
  output logic [FLEN-1:0]               result_data,
  output logic [DROP_CNT_W-1:0]         drop_count,
  output logic                          busy
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic [FLEN-1:0]       data;
  } slot_t;

  logic                    r_valid;
  slot_t                   r_slot;
  logic [PW-1:0]           r_ptr;
  logic [2**X_ID_WIDTH-1:0] r_killed;
  logic [DROP_CNT_W-1:0]   r_drops;

  logic                    w_free;
  logic                    w_en;
  logic [NUM_SRC-1:0]      w_gnt;
  logic [PW-1:0]           w_idx;
  logic                    w_grant;
  slot_t                   w_sel;
  logic                    w_commit_kill;
  logic                    w_kill_set;
  logic                    w_drop;

  assign w_free = !r_valid || result_ready;
  assign w_en   = w_free && !rst;

  rvfpm_rr_arb #(.N(NUM_SRC), .PW(PW)) u_rr_arb (
    .i_req (src_valid),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_grant = |w_gnt;

  always_comb begin
    w_sel      = '0;
    w_sel.id   = src_id[int'(w_idx)*X_ID_WIDTH +: X_ID_WIDTH];
    w_sel.rd   = src_rd[int'(w_idx)*5 +: 5];
    w_sel.data = src_data[int'(w_idx)*FLEN +: FLEN];
  end

  // A kill aimed at the result already on the port is too late to retract it.
  assign w_commit_kill = commit_valid && commit_kill;
  assign w_kill_set    = w_commit_kill && !(r_valid && commit_id == r_slot.id);
  assign w_drop        = w_grant &&
                         (r_killed[w_sel.id] || (w_commit_kill && commit_id == w_sel.id));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_slot   <= '0;
      r_ptr    <= '0;
      // NOTE: the kill table is a small flop array, so it is cleared by reset like any register.
      r_killed <= '0;
      r_drops  <= '0;
    end else begin
      if (w_kill_set) r_killed[commit_id] <= 1'b1;
      // Later assignment wins: a same-cycle kill and drop of one ID leaves the bit clear.
      if (w_drop)     r_killed[w_sel.id]  <= 1'b0;

      if (w_grant) begin
        r_ptr <= (w_idx == PW'(NUM_SRC-1)) ? '0 : w_idx + 1'b1;
      end

      if (w_grant && !w_drop) begin
        r_valid <= 1'b1;
        r_slot  <= w_sel;
      end else if (result_ready) begin
        r_valid <= 1'b0;
      end

      if (w_drop) r_drops <= sat_inc(r_drops);
    end
  end

  assign src_ready    = w_gnt;
  assign result_valid = r_valid;
  assign result_id    = r_slot.id;
  assign result_rd    = r_slot.rd;
  assign result_data  = r_slot.data;
  assign drop_count   = r_drops;
  assign busy         = r_valid;

endmodule
